// File: rtl/lif_neuron_multi_if.sv
// Pin bundle between the tt_um pin mapping and the multi-channel LIF core.
// The master side drives stimulus and serial parameter load; the slave side is the neuron.
interface lif_neuron_multi_if #(
    parameter int N_CH = 4,
    parameter int IN_W = 3,
    parameter int VW   = 8
);
    logic                 ena;
    logic [N_CH*IN_W-1:0] chan_in;
    logic [1:0]           mode;
    logic                 load_mode;
    logic                 serial_data;
    logic [VW-1:0]        v_mem;
    logic                 spike;
    logic                 params_ready;
    logic                 saturation;
    logic                 activity;
    logic                 refractory;
    logic [7:0]           spike_count;

    modport master (
        output ena, chan_in, mode, load_mode, serial_data,
        input  v_mem, spike, params_ready, saturation, activity, refractory, spike_count
    );

    modport slave (
        input  ena, chan_in, mode, load_mode, serial_data,
        output v_mem, spike, params_ready, saturation, activity, refractory, spike_count
    );
endinterface

// File: rtl/lif_neuron_multi.sv
// N-channel leaky integrate-and-fire neuron with serially loaded threshold,
// leak shift and refractory period, burst-mode reset and a saturating spike counter.
module lif_neuron_multi #(
    parameter int N_CH       = 4,
    parameter int IN_W       = 3,
    parameter int VW         = 8,
    parameter int RW         = 4,
    parameter int DEF_THRESH = 128,
    parameter int DEF_LEAK   = 3,
    parameter int DEF_REFR   = 4
) (
    input  logic clk,
    input  logic rst_n,
    lif_neuron_multi_if.slave bus
);
    localparam int PW = VW + 3 + RW;
    localparam int CW = $clog2(PW + 1);
    localparam int SW = IN_W + 4;
    localparam int NW = VW + SW;
    localparam logic [VW-1:0] MAXV = '1;

    logic [VW-1:0] r_v;
    logic          r_spike;
    logic          r_sat;
    logic          r_activity;
    logic          r_refractory;
    logic [7:0]    r_spike_count;
    logic [RW-1:0] r_refr_cnt;
    logic [VW-1:0] r_thresh;
    logic [2:0]    r_leak;
    logic [RW-1:0] r_refr;
    logic          r_params_ready;
    logic [PW-1:0] r_shadow;
    logic [CW-1:0] r_load_cnt;
    logic          r_load_prev;

    logic [IN_W-1:0] w_chan [N_CH];
    logic [SW-1:0]   w_sum;
    logic [SW-1:0]   w_stim;
    logic [VW-1:0]   w_leak_amt;
    logic [NW-1:0]   w_n;
    logic            w_sat;
    logic [VW-1:0]   w_clip;
    logic            w_fire;
    logic            w_burst;
    logic [VW-1:0]   w_v_next;
    logic [RW-1:0]   w_refr_next;
    logic            w_spike_next;
    logic            w_sat_next;
    logic [7:0]      w_count_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign w_chan[gi] = bus.chan_in[gi*IN_W +: IN_W];
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = w_sum + SW'(w_chan[k]);
        end
    end

    always_comb begin
        w_stim = w_sum;
        case (bus.mode)
            2'b01:   w_stim = w_sum << 1;
            2'b10:   w_stim = w_sum >> 1;
            default: w_stim = w_sum;
        endcase
    end

    assign w_burst    = (bus.mode == 2'b11);
    assign w_leak_amt = (r_leak == 3'd0) ? '0 : (r_v >> r_leak);
    // v - L never underflows, so full-width add then clip is enough
    assign w_n    = NW'(r_v) - NW'(w_leak_amt) + NW'(w_stim);
    assign w_sat  = (w_n > NW'(MAXV));
    assign w_clip = w_sat ? MAXV : w_n[VW-1:0];
    assign w_fire = (w_clip >= r_thresh);

    always_comb begin
        w_v_next     = r_v;
        w_refr_next  = r_refr_cnt;
        w_spike_next = 1'b0;
        w_sat_next   = 1'b0;
        w_count_next = r_spike_count;
        if (r_refr_cnt != '0) begin
            w_refr_next = r_refr_cnt - RW'(1);
        end else begin
            w_sat_next = w_sat;
            if (w_fire) begin
                w_spike_next = 1'b1;
                w_v_next     = w_burst ? (r_thresh >> 1) : '0;
                w_refr_next  = w_burst ? '0 : r_refr;
                if (r_spike_count != 8'hFF) begin
                    w_count_next = r_spike_count + 8'd1;
                end
            end else begin
                w_v_next = w_clip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v            <= '0;
            r_spike        <= 1'b0;
            r_sat          <= 1'b0;
            r_activity     <= 1'b0;
            r_refractory   <= 1'b0;
            r_spike_count  <= '0;
            r_refr_cnt     <= '0;
            r_thresh       <= VW'(DEF_THRESH);
            r_leak         <= 3'(DEF_LEAK);
            r_refr         <= RW'(DEF_REFR);
            r_params_ready <= 1'b0;
            r_shadow       <= '0;
            r_load_cnt     <= '0;
            r_load_prev    <= 1'b0;
        end else if (bus.ena) begin
            r_v           <= w_v_next;
            r_spike       <= w_spike_next;
            r_sat         <= w_sat_next;
            r_activity    <= (w_v_next != '0);
            r_refractory  <= (w_refr_next != '0);
            r_spike_count <= w_count_next;
            r_refr_cnt    <= w_refr_next;
            r_load_prev   <= bus.load_mode;

            if (bus.load_mode) begin
                if (!r_load_prev) begin
                    r_params_ready <= 1'b0;
                end
                r_shadow <= {r_shadow[PW-2:0], bus.serial_data};
                if (r_load_cnt != CW'(PW)) begin
                    r_load_cnt <= r_load_cnt + CW'(1);
                end
            end else if (r_load_prev) begin
                // short frames are dropped; the previous active set stays in force
                if (r_load_cnt == CW'(PW)) begin
                    r_thresh       <= r_shadow[PW-1 -: VW];
                    r_leak         <= r_shadow[RW+2 -: 3];
                    r_refr         <= r_shadow[RW-1:0];
                    r_params_ready <= 1'b1;
                end
                r_load_cnt <= '0;
            end
        end
    end

    assign bus.v_mem        = r_v;
    assign bus.spike        = r_spike;
    assign bus.saturation   = r_sat;
    assign bus.activity     = r_activity;
    assign bus.refractory   = r_refractory;
    assign bus.spike_count  = r_spike_count;
    assign bus.params_ready = r_params_ready;
endmodule

// File: tb/tb_lif_neuron_multi.sv
// Directed-vector bench for lif_neuron_multi with hand-computed membrane sequences.
module tb_lif_neuron_multi;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    lif_neuron_multi_if #(.N_CH(4), .IN_W(3), .VW(8)) bus ();

    lif_neuron_multi #(
        .N_CH(4), .IN_W(3), .VW(8), .RW(4),
        .DEF_THRESH(128), .DEF_LEAK(3), .DEF_REFR(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.ena         = 1'b1;
        bus.chan_in     = '0;
        bus.mode        = 2'b00;
        bus.load_mode   = 1'b0;
        bus.serial_data = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_frame(input logic [31:0] val, input int nbits, input bit check_first);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.load_mode   = 1'b1;
            bus.serial_data = val[i];
            step();
            if (check_first && i == nbits - 1) chk("ready_cleared_on_load", 32'(bus.params_ready), 0);
        end
        bus.load_mode   = 1'b0;
        bus.serial_data = 1'b0;
        step();
    endtask

    task automatic run_expect(input string tag, input int vals[$]);
        foreach (vals[i]) begin
            step();
            chk(tag, 32'(bus.v_mem), 32'(vals[i]));
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;

        // reset state and persistence
        do_reset();
        chk("rst_v", 32'(bus.v_mem), 0);
        chk("rst_spike", 32'(bus.spike), 0);
        chk("rst_ready", 32'(bus.params_ready), 0);
        chk("rst_count", 32'(bus.spike_count), 0);
        chk("rst_act", 32'(bus.activity), 0);
        chk("rst_refr", 32'(bus.refractory), 0);
        step();
        step();
        chk("idle_v", 32'(bus.v_mem), 0);
        chk("idle_spike", 32'(bus.spike), 0);

        // defaults, normal mode, stim 28
        bus.chan_in = 12'hFFF;
        run_expect("norm_v", '{28, 53, 75, 94, 111, 126});
        chk("norm_act", 32'(bus.activity), 1);
        step();
        chk("norm_spike", 32'(bus.spike), 1);
        chk("norm_spike_v", 32'(bus.v_mem), 0);
        chk("norm_refr", 32'(bus.refractory), 1);
        chk("norm_count", 32'(bus.spike_count), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("refr_hold_v", 32'(bus.v_mem), 0);
            chk("refr_flag", 32'(bus.refractory), 1);
            chk("refr_spike", 32'(bus.spike), 0);
        end
        step();
        chk("refr_last_v", 32'(bus.v_mem), 0);
        chk("refr_done", 32'(bus.refractory), 0);
        step();
        chk("post_refr_v", 32'(bus.v_mem), 28);

        // amplified mode, stim 56
        do_reset();
        bus.chan_in = 12'hFFF;
        bus.mode    = 2'b01;
        run_expect("amp_v", '{56, 105});
        step();
        chk("amp_spike", 32'(bus.spike), 1);
        chk("amp_spike_v", 32'(bus.v_mem), 0);

        // burst mode, stim 28
        do_reset();
        bus.chan_in = 12'hFFF;
        bus.mode    = 2'b11;
        run_expect("burst_v", '{28, 53, 75, 94, 111, 126});
        step();
        chk("burst_spike", 32'(bus.spike), 1);
        chk("burst_v_reset", 32'(bus.v_mem), 64);
        chk("burst_no_refr", 32'(bus.refractory), 0);
        run_expect("burst_v2", '{84, 102, 118});
        chk("burst_nospike", 32'(bus.spike), 0);
        step();
        chk("burst_spike2", 32'(bus.spike), 1);
        chk("burst_v_reset2", 32'(bus.v_mem), 64);
        chk("burst_count", 32'(bus.spike_count), 2);

        // short frame is discarded
        do_reset();
        load_frame(32'h3FF, 10, 1'b0);
        chk("short_ready", 32'(bus.params_ready), 0);
        bus.chan_in = 12'hFFF;
        run_expect("short_v", '{28, 53, 75, 94, 111, 126});
        step();
        chk("short_spike", 32'(bus.spike), 1);

        // reset mid-frame clears the bit counter: 8 + 7 bits must not commit
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.load_mode = 1'b1; bus.serial_data = 1'b1; step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.load_mode = 1'b1; bus.serial_data = 1'b0; step();
        end
        bus.load_mode = 1'b0;
        step();
        chk("midrst_ready", 32'(bus.params_ready), 0);

        // thresh=40 leak=0 refr=0
        do_reset();
        load_frame(32'h1400, 15, 1'b0);
        chk("t40_ready", 32'(bus.params_ready), 1);
        bus.chan_in = 12'hFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t40_v", 32'(bus.v_mem), 28);
            chk("t40_nospike", 32'(bus.spike), 0);
            step();
            chk("t40_spike", 32'(bus.spike), 1);
            chk("t40_spike_v", 32'(bus.v_mem), 0);
        end
        chk("t40_count", 32'(bus.spike_count), 2);

        // thresh=255 leak=0 refr=0, amplified, clip at full scale
        bus.chan_in = '0;
        load_frame(32'h7F80, 15, 1'b1);
        chk("t255_ready", 32'(bus.params_ready), 1);
        bus.chan_in = 12'hFFF;
        bus.mode    = 2'b01;
        run_expect("t255_v", '{56, 112, 168, 224});
        chk("t255_nosat", 32'(bus.saturation), 0);
        step();
        chk("t255_sat", 32'(bus.saturation), 1);
        chk("t255_spike", 32'(bus.spike), 1);
        chk("t255_v_after", 32'(bus.v_mem), 0);
        chk("t255_count", 32'(bus.spike_count), 3);

        // ena=0 freezes everything, including the load path
        bus.ena         = 1'b0;
        bus.load_mode   = 1'b1;
        bus.serial_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_spike", 32'(bus.spike), 1);
            chk("frz_sat", 32'(bus.saturation), 1);
            chk("frz_v", 32'(bus.v_mem), 0);
            chk("frz_ready", 32'(bus.params_ready), 1);
        end
        bus.load_mode = 1'b0;
        bus.ena       = 1'b1;
        step();
        chk("resume_v", 32'(bus.v_mem), 56);
        chk("resume_spike", 32'(bus.spike), 0);
        chk("resume_sat", 32'(bus.saturation), 0);
        chk("resume_count", 32'(bus.spike_count), 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
